// File: rtl/pl_key_pkg.sv
// Shared types and default constants for the PL push-button debouncer.
package pl_key_pkg;

  // Board system clock frequency
  localparam int SYS_CLK_HZ = 50_000_000;

  // 20 ms debounce window at SYS_CLK_HZ
  localparam int DEBOUNCE_CYCLES_DEF = SYS_CLK_HZ / 50;

  // 1 s long-press threshold at SYS_CLK_HZ
  localparam int LONG_CYCLES_DEF = SYS_CLK_HZ;

  // Per-key channel FSM: IDLE = released, PRESSED = held, LONG = long-press already reported
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESSED = 2'd1,
    LONG    = 2'd2
  } key_fsm_e;

endpackage

// File: rtl/pl_key_channel.sv
// One key channel: 2-flop synchroniser, debounce counter, press/release/long FSM.
// The FSM state is the debounced level (IDLE = released) and is exported for debug.
module pl_key_channel
  import pl_key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic     sys_clk,
  input  logic     rst,
  input  logic     key_in,
  output key_fsm_e state,
  output logic     key_press,
  output logic     key_release,
  output logic     key_long
);

  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int HOLD_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic              sync1;
  logic              sync2;
  logic              key_sync;
  logic              key_level;
  logic              differ;
  logic              accept;
  logic [DB_W-1:0]   db_cnt;
  logic [HOLD_W-1:0] hold_cnt;

  // Synchronise the raw pin; reset value 1 means "released" on the active-low pin
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  assign key_sync  = ~sync2;
  assign key_level = (state != IDLE);
  assign differ    = (key_sync != key_level);
  // A level change is accepted on the DEBOUNCE_CYCLES-th consecutive differing cycle
  assign accept    = differ && (db_cnt == DB_LAST);

  // Count consecutive cycles the synchronised key disagrees with the debounced level
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      db_cnt <= '0;
    end else if (!differ || accept) begin
      db_cnt <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Channel FSM with registered single-cycle event pulses; release has priority over long
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state       <= IDLE;
      hold_cnt    <= '0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
      case (state)
        IDLE: begin
          hold_cnt <= '0;
          if (accept) begin
            state     <= PRESSED;
            key_press <= 1'b1;
          end
        end
        PRESSED: begin
          if (accept) begin
            state       <= IDLE;
            key_release <= 1'b1;
            hold_cnt    <= '0;
          end else if (hold_cnt == HOLD_LAST) begin
            state    <= LONG;
            key_long <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        LONG: begin
          if (accept) begin
            state       <= IDLE;
            key_release <= 1'b1;
            hold_cnt    <= '0;
          end
        end
        default: begin
          state    <= IDLE;
          hold_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pl_key_debounce.sv
// NUM_KEYS independent active-low push-button debouncers with press/release/long events.
module pl_key_debounce
  import pl_key_pkg::*;
#(
  parameter int NUM_KEYS        = 4,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int LONG_CYCLES     = LONG_CYCLES_DEF
) (
  input  logic                sys_clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long
);

  key_fsm_e ch_state [NUM_KEYS];

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_ch
    pl_key_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .LONG_CYCLES    (LONG_CYCLES)
    ) u_ch (
      .sys_clk    (sys_clk),
      .rst        (rst),
      .key_in     (key_in[g]),
      .state      (ch_state[g]),
      .key_press  (key_press[g]),
      .key_release(key_release[g]),
      .key_long   (key_long[g])
    );

    // Debounced level is a decode of the registered channel state
    assign key_state[g] = (ch_state[g] != IDLE);
  end

endmodule

// File: tb/tb_pl_key_debounce.sv
// Bench for pl_key_debounce with DEBOUNCE_CYCLES=8, LONG_CYCLES=32.
// Each step drives inputs just after a rising edge and checks outputs 1 time unit after the next one.
module tb_pl_key_debounce;

  localparam int NK = 4;

  logic          sys_clk;
  logic          rst;
  logic [NK-1:0] key_in;
  logic [NK-1:0] key_state;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic [NK-1:0] key_long;

  int n_checks;
  int n_fail;

  // ---------------- clock / reset ----------------
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  pl_key_debounce #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(8),
    .LONG_CYCLES    (32)
  ) dut (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic          rst;
    logic [NK-1:0] key;
    logic [NK-1:0] st;
    logic [NK-1:0] pr;
    logic [NK-1:0] rl;
    logic [NK-1:0] lg;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int n, logic r, logic [NK-1:0] k, logic [NK-1:0] st,
                              logic [NK-1:0] pr, logic [NK-1:0] rl, logic [NK-1:0] lg);
    vec_t v;
    v.rst = r; v.key = k; v.st = st; v.pr = pr; v.rl = rl; v.lg = lg;
    for (int i = 0; i < n; i++) vecs.push_back(v);
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- driver / event monitor ----------------
  int cyc;
  int press_cnt[NK], rel_cnt[NK], long_cnt[NK];
  int press_at[NK], rel_at[NK], long_at[NK];

  task automatic clear_mon();
    cyc = 0;
    for (int b = 0; b < NK; b++) begin
      press_cnt[b] = 0; rel_cnt[b] = 0; long_cnt[b] = 0;
      press_at[b] = -1; rel_at[b] = -1; long_at[b] = -1;
    end
  endtask

  task automatic step(logic r, logic [NK-1:0] k);
    rst    = r;
    key_in = k;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic run(int n, logic r, logic [NK-1:0] k);
    for (int i = 0; i < n; i++) begin
      step(r, k);
      cyc++;
      check("press_release_exclusive", 32'(key_press & key_release), 32'd0);
      for (int b = 0; b < NK; b++) begin
        if (key_press[b])   begin press_cnt[b]++; if (press_at[b] < 0) press_at[b] = cyc; end
        if (key_release[b]) begin rel_cnt[b]++;   if (rel_at[b]   < 0) rel_at[b]   = cyc; end
        if (key_long[b])    begin long_cnt[b]++;  if (long_at[b]  < 0) long_at[b]  = cyc; end
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    key_in   = '1;

    // Reset with all keys held, then release reset: press on the 10th cycle
    add(3, 1, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
    add(9, 0, 4'b0000, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b0000, 4'hF, 4'hF, 4'h0, 4'h0);
    add(2, 0, 4'b0000, 4'hF, 4'h0, 4'h0, 4'h0);
    add(9, 0, 4'b1111, 4'hF, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b1111, 4'h0, 4'h0, 4'hF, 4'h0);
    add(2, 0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    // Glitch of 7 cycles on key0 is rejected
    add(7, 0, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);
    add(12, 0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    // 8-cycle low on key0 is accepted 10 edges after the fall, then released
    add(8, 0, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b1111, 4'h1, 4'h1, 4'h0, 4'h0);
    add(7, 0, 4'b1111, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b1111, 4'h0, 4'h0, 4'h1, 4'h0);
    add(3, 0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    // Short press on key0 held 20 cycles: press, release, no long
    add(9, 0, 4'b1110, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b1110, 4'h1, 4'h1, 4'h0, 4'h0);
    add(10, 0, 4'b1110, 4'h1, 4'h0, 4'h0, 4'h0);
    add(9, 0, 4'b1111, 4'h1, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b1111, 4'h0, 4'h0, 4'h1, 4'h0);
    add(3, 0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);
    // key1: release accepted on the edge the long press would fire; release wins
    add(9, 0, 4'b1101, 4'h0, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b1101, 4'h2, 4'h2, 4'h0, 4'h0);
    add(22, 0, 4'b1101, 4'h2, 4'h0, 4'h0, 4'h0);
    add(9, 0, 4'b1111, 4'h2, 4'h0, 4'h0, 4'h0);
    add(1, 0, 4'b1111, 4'h0, 4'h0, 4'h2, 4'h0);
    add(3, 0, 4'b1111, 4'h0, 4'h0, 4'h0, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].key);
      check($sformatf("vec[%0d] {state,press,release,long}", i),
            32'({key_state, key_press, key_release, key_long}),
            32'({vecs[i].st, vecs[i].pr, vecs[i].rl, vecs[i].lg}));
    end

    // Long press on key2: one key_long exactly 32 cycles after key_press
    clear_mon();
    run(100, 1'b0, 4'b1011);
    check("long.press_at",   32'(press_at[2]), 32'd10);
    check("long.press_cnt",  32'(press_cnt[2]), 32'd1);
    check("long.long_at",    32'(long_at[2]), 32'd42);
    check("long.long_cnt",   32'(long_cnt[2]), 32'd1);
    check("long.state",      32'(key_state), 32'h4);
    check("long.other_keys", 32'(press_cnt[0] + press_cnt[1] + press_cnt[3]), 32'd0);
    clear_mon();
    run(20, 1'b0, 4'b1111);
    check("long.rel_at",     32'(rel_at[2]), 32'd10);
    check("long.rel_cnt",    32'(rel_cnt[2]), 32'd1);
    check("long.no_relong",  32'(long_cnt[2]), 32'd0);

    // key1 and key3 fall together; key1 bounces with 3-cycle segments
    clear_mon();
    for (int s = 0; s < 5; s++) begin
      run(3, 1'b0, (s % 2 == 0) ? 4'b0101 : 4'b0111);
    end
    run(13, 1'b0, 4'b0101);
    check("simul.key3_press_at",  32'(press_at[3]), 32'd10);
    check("simul.key1_press_at",  32'(press_at[1]), 32'd22);
    check("simul.key1_press_cnt", 32'(press_cnt[1]), 32'd1);
    check("simul.key3_press_cnt", 32'(press_cnt[3]), 32'd1);
    check("simul.no_release",     32'(rel_cnt[1] + rel_cnt[3]), 32'd0);
    check("simul.state",          32'(key_state), 32'hA);
    clear_mon();
    run(15, 1'b0, 4'b1111);
    check("simul.key1_rel_at", 32'(rel_at[1]), 32'd10);
    check("simul.key3_rel_at", 32'(rel_at[3]), 32'd10);
    check("simul.no_long",     32'(long_cnt[1] + long_cnt[3]), 32'd0);

    // Reset while key0 is long-held: no release, fresh press after reset
    clear_mon();
    run(50, 1'b0, 4'b1110);
    check("rstmid.long_cnt", 32'(long_cnt[0]), 32'd1);
    clear_mon();
    run(1, 1'b1, 4'b1110);
    check("rstmid.outputs_in_reset",
          32'({key_state, key_press, key_release, key_long}), 32'd0);
    clear_mon();
    run(15, 1'b0, 4'b1110);
    check("rstmid.press_at", 32'(press_at[0]), 32'd10);
    check("rstmid.no_rel",   32'(rel_cnt[0]), 32'd0);
    check("rstmid.state",    32'(key_state), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
